// File: rtl/mem_stage.sv
// MEM stage of the 5-stage pipeline: EX/MEM register, word-addressed data memory,
// branch resolution and the MEM/WB register feeding write-back and forwarding.
module mem_stage #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] alu_result,
    input  logic        zero_flag,
    input  logic [31:0] store_data,
    input  logic [4:0]  dest_reg,
    input  logic [31:0] branch_target,
    input  logic        reg_write_in,
    input  logic        mem_to_reg_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic        branch_eq_in,
    input  logic        branch_ne_in,
    output logic [31:0] ex_mem_result,
    output logic [4:0]  ex_mem_dest,
    output logic        ex_mem_reg_write,
    output logic        pc_src,
    output logic [31:0] pc_branch,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_dest,
    output logic        wb_reg_write,
    output logic        misalign_err,
    output logic [31:0] access_count
);

    // EX/MEM pipeline register
    logic [31:0] em_result_q;
    logic        em_zero_q;
    logic [31:0] em_store_q;
    logic [4:0]  em_dest_q;
    logic [31:0] em_target_q;
    logic        em_reg_write_q;
    logic        em_mem_to_reg_q;
    logic        em_mem_read_q;
    logic        em_mem_write_q;
    logic        em_branch_eq_q;
    logic        em_branch_ne_q;

    // MEM/WB pipeline register and status
    logic [31:0] wb_data_q,  wb_data_d;
    logic [4:0]  wb_dest_q,  wb_dest_d;
    logic        wb_reg_write_q, wb_reg_write_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q,    count_d;

    logic [31:0] ram [DEPTH];

    logic              aligned;
    logic              mem_op;
    logic [ADDR_W-1:0] word_idx;
    logic [31:0]       rd_data;

    // Flush outranks stall so that flush+stall still inserts a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            em_result_q     <= '0;
            em_zero_q       <= 1'b0;
            em_store_q      <= '0;
            em_dest_q       <= '0;
            em_target_q     <= '0;
            em_reg_write_q  <= 1'b0;
            em_mem_to_reg_q <= 1'b0;
            em_mem_read_q   <= 1'b0;
            em_mem_write_q  <= 1'b0;
            em_branch_eq_q  <= 1'b0;
            em_branch_ne_q  <= 1'b0;
        end else if (flush) begin
            em_result_q     <= '0;
            em_zero_q       <= 1'b0;
            em_store_q      <= '0;
            em_dest_q       <= '0;
            em_target_q     <= '0;
            em_reg_write_q  <= 1'b0;
            em_mem_to_reg_q <= 1'b0;
            em_mem_read_q   <= 1'b0;
            em_mem_write_q  <= 1'b0;
            em_branch_eq_q  <= 1'b0;
            em_branch_ne_q  <= 1'b0;
        end else if (!stall) begin
            em_result_q     <= alu_result;
            em_zero_q       <= zero_flag;
            em_store_q      <= store_data;
            em_dest_q       <= dest_reg;
            em_target_q     <= branch_target;
            em_reg_write_q  <= reg_write_in;
            em_mem_to_reg_q <= mem_to_reg_in;
            em_mem_read_q   <= mem_read_in;
            em_mem_write_q  <= mem_write_in;
            em_branch_eq_q  <= branch_eq_in;
            em_branch_ne_q  <= branch_ne_in;
        end
    end

    // Upper address bits are dropped, so addresses wrap modulo DEPTH words.
    assign aligned  = (em_result_q[1:0] == 2'b00);
    assign mem_op   = em_mem_read_q | em_mem_write_q;
    assign word_idx = em_result_q[ADDR_W+1:2];
    assign rd_data  = ram[word_idx];

    // Memory contents survive reset; a store caught by reset is already cleared in EX/MEM.
    always_ff @(posedge clk) begin
        if (em_mem_write_q && aligned && !stall) begin
            ram[word_idx] <= em_store_q;
        end
    end

    always_comb begin
        wb_data_d      = wb_data_q;
        wb_dest_d      = wb_dest_q;
        wb_reg_write_d = wb_reg_write_q;
        misalign_d     = misalign_q;
        count_d        = count_q;
        if (!stall) begin
            wb_data_d      = (em_mem_to_reg_q && em_mem_read_q && aligned) ? rd_data : em_result_q;
            wb_dest_d      = em_dest_q;
            wb_reg_write_d = em_reg_write_q && !(em_mem_read_q && !aligned);
            if (mem_op && !aligned) begin
                misalign_d = 1'b1;
            end
            if (mem_op && aligned) begin
                count_d = count_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_data_q      <= '0;
            wb_dest_q      <= '0;
            wb_reg_write_q <= 1'b0;
            misalign_q     <= 1'b0;
            count_q        <= '0;
        end else begin
            wb_data_q      <= wb_data_d;
            wb_dest_q      <= wb_dest_d;
            wb_reg_write_q <= wb_reg_write_d;
            misalign_q     <= misalign_d;
            count_q        <= count_d;
        end
    end

    assign ex_mem_result    = em_result_q;
    assign ex_mem_dest      = em_dest_q;
    assign ex_mem_reg_write = em_reg_write_q;
    assign pc_src           = (em_branch_eq_q & em_zero_q) | (em_branch_ne_q & ~em_zero_q);
    assign pc_branch        = em_target_q;
    assign wb_data          = wb_data_q;
    assign wb_dest          = wb_dest_q;
    assign wb_reg_write     = wb_reg_write_q;
    assign misalign_err     = misalign_q;
    assign access_count     = count_q;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios plus a random run against an
// instruction-level model of the MEM stage.
module tb_mem_stage;

    localparam int DEPTH = 256;

    typedef struct packed {
        logic [31:0] result;
        logic        zero;
        logic [31:0] sdata;
        logic [4:0]  dest;
        logic [31:0] target;
        logic        rw;
        logic        m2r;
        logic        mr;
        logic        mw;
        logic        beq;
        logic        bne;
    } instr_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] alu_result = '0;
    logic        zero_flag = 1'b0;
    logic [31:0] store_data = '0;
    logic [4:0]  dest_reg = '0;
    logic [31:0] branch_target = '0;
    logic        reg_write_in = 1'b0;
    logic        mem_to_reg_in = 1'b0;
    logic        mem_read_in = 1'b0;
    logic        mem_write_in = 1'b0;
    logic        branch_eq_in = 1'b0;
    logic        branch_ne_in = 1'b0;
    logic [31:0] ex_mem_result;
    logic [4:0]  ex_mem_dest;
    logic        ex_mem_reg_write;
    logic        pc_src;
    logic [31:0] pc_branch;
    logic [31:0] wb_data;
    logic [4:0]  wb_dest;
    logic        wb_reg_write;
    logic        misalign_err;
    logic [31:0] access_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the instruction sitting in MEM and the last write-back result.
    instr_t      m_em;
    bit          m_em_valid;
    logic [31:0] m_wb_data;
    bit          m_wb_known;
    bit          m_wb_valid;
    logic [4:0]  m_wb_dest;
    bit          m_wb_rw;
    bit          m_mis;
    logic [31:0] m_cnt;
    logic [31:0] m_ram [int];

    mem_stage #(.DEPTH(DEPTH), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .alu_result(alu_result), .zero_flag(zero_flag), .store_data(store_data),
        .dest_reg(dest_reg), .branch_target(branch_target),
        .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .branch_eq_in(branch_eq_in), .branch_ne_in(branch_ne_in),
        .ex_mem_result(ex_mem_result), .ex_mem_dest(ex_mem_dest),
        .ex_mem_reg_write(ex_mem_reg_write), .pc_src(pc_src), .pc_branch(pc_branch),
        .wb_data(wb_data), .wb_dest(wb_dest), .wb_reg_write(wb_reg_write),
        .misalign_err(misalign_err), .access_count(access_count)
    );

    always #5 clk = ~clk;

    function automatic instr_t nop();
        instr_t i;
        i = '0;
        return i;
    endfunction

    function automatic instr_t alu_op(input logic [31:0] res, input logic [4:0] d);
        instr_t i;
        i = '0; i.result = res; i.dest = d; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t sw_op(input logic [31:0] addr, input logic [31:0] data);
        instr_t i;
        i = '0; i.result = addr; i.sdata = data; i.mw = 1'b1;
        return i;
    endfunction

    function automatic instr_t lw_op(input logic [31:0] addr, input logic [4:0] d);
        instr_t i;
        i = '0; i.result = addr; i.dest = d; i.mr = 1'b1; i.m2r = 1'b1; i.rw = 1'b1;
        return i;
    endfunction

    function automatic instr_t br_op(input bit ne, input bit z, input logic [31:0] tgt);
        instr_t i;
        i = '0; i.zero = z; i.target = tgt; i.beq = !ne; i.bne = ne;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        logic [31:0] addr;
        addr = 32'($urandom_range(0, 31)) * 4;
        if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 3));
        if ($urandom_range(0, 3) == 0) addr = addr + 32'h400 * 32'($urandom_range(1, 8));
        case ($urandom_range(0, 3))
            0: i = alu_op($urandom, 5'($urandom));
            1: i = lw_op(addr, 5'($urandom));
            2: i = sw_op(addr, $urandom);
            default: i = br_op($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
        endcase
        i.zero = $urandom_range(0, 1) == 1;
        return i;
    endfunction

    task automatic model_reset();
        m_em = '0; m_em_valid = 1'b1;
        m_wb_data = '0; m_wb_known = 1'b1; m_wb_valid = 1'b1;
        m_wb_dest = '0; m_wb_rw = 1'b0; m_mis = 1'b0; m_cnt = '0;
    endtask

    // Present one instruction for one clock and advance the model by one edge.
    task automatic cycle(input instr_t in, input bit st, input bit fl);
        bit al;
        bit is_mem;
        int idx;
        alu_result = in.result; zero_flag = in.zero; store_data = in.sdata;
        dest_reg = in.dest; branch_target = in.target;
        reg_write_in = in.rw; mem_to_reg_in = in.m2r; mem_read_in = in.mr;
        mem_write_in = in.mw; branch_eq_in = in.beq; branch_ne_in = in.bne;
        stall = st; flush = fl;
        al = (m_em.result % 4) == 0;
        idx = int'((m_em.result / 4) % DEPTH);
        is_mem = m_em.mr || m_em.mw;
        if (!st) begin
            if (is_mem && !al) m_mis = 1'b1;
            if (is_mem && al) m_cnt = m_cnt + 1;
            m_wb_valid = m_em_valid;
            m_wb_dest = m_em.dest;
            m_wb_rw = m_em.rw && !(m_em.mr && !al);
            if (m_em.m2r && m_em.mr && al) begin
                m_wb_known = m_ram.exists(idx);
                m_wb_data = m_wb_known ? m_ram[idx] : 32'h0;
            end else begin
                m_wb_known = m_em_valid;
                m_wb_data = m_em.result;
            end
            if (m_em.mw && al) m_ram[idx] = m_em.sdata;
        end
        if (fl) begin
            m_em = '0; m_em_valid = 1'b0;
        end else if (!st) begin
            m_em = in; m_em_valid = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rst_wb_reg_write got %0b exp 0", wb_reg_write); end
        checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL rst_wb_data got %h exp 0", wb_data); end
        checks++; if (ex_mem_reg_write !== 1'b0) begin errors++; $display("FAIL rst_ex_mem_reg_write got %0b exp 0", ex_mem_reg_write); end
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL rst_pc_src got %0b exp 0", pc_src); end
        checks++; if (access_count !== 32'h0) begin errors++; $display("FAIL rst_access_count got %0d exp 0", access_count); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("FAIL rst_misalign got %0b exp 0", misalign_err); end
    endtask

    task automatic test_store_load();
        cycle(sw_op(32'h10, 32'hDEADBEEF), 0, 0);
        cycle(lw_op(32'h10, 5'd7), 0, 0);
        checks++; if (ex_mem_dest !== 5'd7) begin errors++; $display("FAIL sl_ex_mem_dest got %0d exp 7", ex_mem_dest); end
        cycle(nop(), 0, 0);
        checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL sl_wb_data got %h exp deadbeef", wb_data); end
        checks++; if (wb_dest !== 5'd7) begin errors++; $display("FAIL sl_wb_dest got %0d exp 7", wb_dest); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL sl_wb_reg_write got %0b exp 1", wb_reg_write); end
        checks++; if (access_count !== 32'd2) begin errors++; $display("FAIL sl_access_count got %0d exp 2", access_count); end
    endtask

    task automatic test_branch();
        cycle(br_op(0, 1, 32'h40), 0, 0);
        checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL beq_taken got %0b exp 1", pc_src); end
        checks++; if (pc_branch !== 32'h40) begin errors++; $display("FAIL beq_target got %h exp 40", pc_branch); end
        cycle(br_op(0, 0, 32'h40), 0, 0);
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL beq_not_taken got %0b exp 0", pc_src); end
        cycle(br_op(1, 1, 32'h80), 0, 0);
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL bne_not_taken got %0b exp 0", pc_src); end
        cycle(br_op(1, 0, 32'h80), 0, 0);
        checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL bne_taken got %0b exp 1", pc_src); end
        checks++; if (pc_branch !== 32'h80) begin errors++; $display("FAIL bne_target got %h exp 80", pc_branch); end
    endtask

    task automatic test_stall_flush();
        logic [31:0] cnt0;
        cycle(alu_op(32'h55, 5'd3), 0, 0);
        cycle(sw_op(32'h20, 32'hA5A5_0001), 0, 0);
        cnt0 = m_cnt;
        for (int k = 0; k < 3; k++) begin
            cycle(nop(), 1, 0);
            checks++; if (access_count !== cnt0) begin errors++; $display("FAIL stall_count got %0d exp %0d", access_count, cnt0); end
            checks++; if (ex_mem_result !== 32'h20) begin errors++; $display("FAIL stall_em_hold got %h exp 20", ex_mem_result); end
            checks++; if (wb_data !== 32'h55 || wb_dest !== 5'd3) begin errors++; $display("FAIL stall_wb_hold got %h/%0d exp 55/3", wb_data, wb_dest); end
        end
        cycle(lw_op(32'h20, 5'd4), 0, 0);
        checks++; if (access_count !== cnt0 + 1) begin errors++; $display("FAIL stall_single_write got %0d exp %0d", access_count, cnt0 + 1); end
        cycle(nop(), 0, 0);
        checks++; if (wb_data !== 32'hA5A5_0001) begin errors++; $display("FAIL stall_readback got %h exp a5a50001", wb_data); end
        cycle(alu_op(32'h77, 5'd5), 0, 1);
        checks++; if (ex_mem_reg_write !== 1'b0) begin errors++; $display("FAIL flush_em got %0b exp 0", ex_mem_reg_write); end
        cycle(nop(), 0, 0);
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_wb got %0b exp 0", wb_reg_write); end
        cycle(alu_op(32'h66, 5'd6), 0, 0);
        cycle(alu_op(32'h99, 5'd8), 1, 1);
        checks++; if (ex_mem_reg_write !== 1'b0) begin errors++; $display("FAIL flush_stall_bubble got %0b exp 0", ex_mem_reg_write); end
        cycle(nop(), 0, 0);
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL flush_stall_wb got %0b exp 0", wb_reg_write); end
    endtask

    task automatic test_misaligned();
        cycle(sw_op(32'h13, 32'h1234_5678), 0, 0);
        cycle(lw_op(32'h10, 5'd9), 0, 0);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_set got %0b exp 1", misalign_err); end
        cycle(lw_op(32'h22, 5'd10), 0, 0);
        checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL mis_ram_unchanged got %h exp deadbeef", wb_data); end
        cycle(nop(), 0, 0);
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL mis_load_rw got %0b exp 0", wb_reg_write); end
        cycle(alu_op(32'h4, 5'd1), 0, 0);
        checks++; if (misalign_err !== 1'b1) begin errors++; $display("FAIL mis_sticky got %0b exp 1", misalign_err); end
    endtask

    task automatic test_wrap();
        cycle(sw_op(32'h400, 32'hCAFE_F00D), 0, 0);
        cycle(lw_op(32'h0, 5'd11), 0, 0);
        cycle(nop(), 0, 0);
        checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL wrap_word0 got %h exp cafef00d", wb_data); end
    endtask

    task automatic test_random();
        instr_t in;
        bit st;
        bit fl;
        for (int n = 0; n < 400; n++) begin
            in = rand_instr();
            st = $urandom_range(0, 7) == 0;
            fl = $urandom_range(0, 9) == 0;
            cycle(in, st, fl);
            checks++;
            if (ex_mem_reg_write !== m_em.rw) begin errors++; $display("FAIL rnd_em_rw n=%0d got %0b exp %0b", n, ex_mem_reg_write, m_em.rw); end
            checks++;
            if (pc_src !== ((m_em.beq && m_em.zero) || (m_em.bne && !m_em.zero))) begin errors++; $display("FAIL rnd_pc_src n=%0d got %0b", n, pc_src); end
            if (m_em_valid) begin
                checks++;
                if (ex_mem_result !== m_em.result || ex_mem_dest !== m_em.dest || pc_branch !== m_em.target) begin
                    errors++; $display("FAIL rnd_em_fields n=%0d got %h/%0d/%h exp %h/%0d/%h", n, ex_mem_result, ex_mem_dest, pc_branch, m_em.result, m_em.dest, m_em.target);
                end
            end
            checks++;
            if (wb_reg_write !== m_wb_rw) begin errors++; $display("FAIL rnd_wb_rw n=%0d got %0b exp %0b", n, wb_reg_write, m_wb_rw); end
            if (m_wb_valid) begin
                checks++;
                if (wb_dest !== m_wb_dest) begin errors++; $display("FAIL rnd_wb_dest n=%0d got %0d exp %0d", n, wb_dest, m_wb_dest); end
            end
            if (m_wb_known) begin
                checks++;
                if (wb_data !== m_wb_data) begin errors++; $display("FAIL rnd_wb_data n=%0d got %h exp %h", n, wb_data, m_wb_data); end
            end
            checks++;
            if (misalign_err !== m_mis || access_count !== m_cnt) begin
                errors++; $display("FAIL rnd_status n=%0d got %0b/%0d exp %0b/%0d", n, misalign_err, access_count, m_mis, m_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(lw_op(32'h10, 5'd12), 0, 0);
        cycle(br_op(0, 1, 32'h100), 0, 0);
        checks++; if (wb_reg_write !== 1'b1 || pc_src !== 1'b1) begin errors++; $display("FAIL ar_pre got %0b/%0b exp 1/1", wb_reg_write, pc_src); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL ar_wb_reg_write got %0b exp 0", wb_reg_write); end
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL ar_pc_src got %0b exp 0", pc_src); end
        checks++; if (access_count !== 32'h0 || misalign_err !== 1'b0) begin errors++; $display("FAIL ar_status got %0d/%0b exp 0/0", access_count, misalign_err); end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(nop(), 0, 0);
        checks++; if (access_count !== 32'h0) begin errors++; $display("FAIL ar_after got %0d exp 0", access_count); end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_branch();
        test_stall_flush();
        test_misaligned();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
